fsm_flow_ctrl: RTL and testbench

//  Parametrised flow-control state machine for the N-FIFO data path. Latches high/low

---
 rtl/fsm_flow_pkg.sv | 22 ++
 rtl/fsm_hyst_chan.sv | 32 +++
 rtl/fsm_flow_ctrl.sv | 110 +++++++++++
 tb/tb_fsm_flow_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fsm_flow_pkg.sv
// Shared state encodings and widths for the FIFO-bank flow-control FSM.
// The optional activity counter is enabled by defining FSM_FLOW_STATS_EN.
package fsm_flow_pkg;

    localparam int STATE_W = 3;
    localparam int STAT_W  = 16;

    localparam logic [STATE_W-1:0] RESET  = 3'd0;
    localparam logic [STATE_W-1:0] INIT   = 3'd1;
    localparam logic [STATE_W-1:0] IDLE   = 3'd2;
    localparam logic [STATE_W-1:0] ACTIVE = 3'd3;
    localparam logic [STATE_W-1:0] ERROR  = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET  = RESET,
        ST_INIT   = INIT,
        ST_IDLE   = IDLE,
        ST_ACTIVE = ACTIVE,
        ST_ERROR  = ERROR
    } state_t;

endpackage

// File: rtl/fsm_hyst_chan.sv
// Per-FIFO pause generator with hysteresis between the low and high thresholds.
// The pause bit is cleared whenever the channel is not enabled.
module fsm_hyst_chan #(
    parameter int LVL_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [LVL_W-1:0] level,
    input  logic [LVL_W-1:0] alto,
    input  logic [LVL_W-1:0] bajo,
    output logic             pause
);

    logic pause_reg;

    // Set takes priority; in-band levels keep the previous decision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pause_reg <= 1'b0;
        end else if (!en) begin
            pause_reg <= 1'b0;
        end else if (level >= alto) begin
            pause_reg <= 1'b1;
        end else if (level <= bajo) begin
            pause_reg <= 1'b0;
        end
    end

    assign pause = pause_reg;

endmodule

// File: rtl/fsm_flow_ctrl.sv
// Flow-control FSM for the N-FIFO data path: threshold latching, idle tracking,
// per-FIFO pause. Optional ACTIVE cycle counter under FSM_FLOW_STATS_EN.
module fsm_flow_ctrl
    import fsm_flow_pkg::*;
#(
    parameter int NUM_FIFOS = 10,
    parameter int LVL_W     = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       init,
    input  logic [LVL_W-1:0]           umbral_alto,
    input  logic [LVL_W-1:0]           umbral_bajo,
    input  logic [NUM_FIFOS-1:0]       fifo_empty,
    input  logic [NUM_FIFOS*LVL_W-1:0] fifo_level,
    output logic [STATE_W-1:0]         state,
    output logic                       idle,
    output logic                       cfg_error,
    output logic [LVL_W-1:0]           interno_alto,
    output logic [LVL_W-1:0]           interno_bajo,
    output logic [NUM_FIFOS-1:0]       pause,
    output logic [STAT_W-1:0]          active_cycles
);

    state_t           state_reg;
    state_t           state_next;
    logic [LVL_W-1:0] interno_alto_reg;
    logic [LVL_W-1:0] interno_bajo_reg;
    logic             cfg_error_reg;
    logic             all_empty;
    logic             chan_en;

    assign all_empty = &fifo_empty;

    always_comb begin
        state_next = ST_RESET;
        if (init && state_reg != ST_RESET) begin
            state_next = ST_INIT;
        end else begin
            case (state_reg)
                ST_RESET:  state_next = ST_INIT;
                ST_INIT:   state_next = (umbral_bajo >= umbral_alto) ? ST_ERROR : ST_IDLE;
                ST_IDLE:   state_next = all_empty ? ST_IDLE : ST_ACTIVE;
                ST_ACTIVE: state_next = all_empty ? ST_IDLE : ST_ACTIVE;
                ST_ERROR:  state_next = ST_ERROR;
                default:   state_next = ST_RESET;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg        <= ST_RESET;
            interno_alto_reg <= '0;
            interno_bajo_reg <= '0;
            cfg_error_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_INIT) begin
                interno_alto_reg <= umbral_alto;
                interno_bajo_reg <= umbral_bajo;
                cfg_error_reg    <= (umbral_bajo >= umbral_alto);
            end
        end
    end

    // Gating on the next state too clears pause on the very edge that leaves ACTIVE.
    assign chan_en = (state_reg == ST_ACTIVE) && (state_next == ST_ACTIVE);

    generate
        for (genvar gi = 0; gi < NUM_FIFOS; gi++) begin : g_chan
            fsm_hyst_chan #(
                .LVL_W (LVL_W)
            ) u_chan (
                .clk   (clk),
                .reset (reset),
                .en    (chan_en),
                .level (fifo_level[gi*LVL_W +: LVL_W]),
                .alto  (interno_alto_reg),
                .bajo  (interno_bajo_reg),
                .pause (pause[gi])
            );
        end
    endgenerate

`ifdef FSM_FLOW_STATS_EN
    logic [STAT_W-1:0] active_cycles_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            active_cycles_reg <= '0;
        end else if (state_next == ST_INIT) begin
            active_cycles_reg <= '0;
        end else if (state_reg == ST_ACTIVE && active_cycles_reg != {STAT_W{1'b1}}) begin
            active_cycles_reg <= active_cycles_reg + 1'b1;
        end
    end

    assign active_cycles = active_cycles_reg;
`else
    assign active_cycles = '0;
`endif

    assign state        = state_reg;
    assign idle         = (state_reg == ST_IDLE) && all_empty;
    assign cfg_error    = cfg_error_reg;
    assign interno_alto = interno_alto_reg;
    assign interno_bajo = interno_bajo_reg;

endmodule

// File: tb/tb_fsm_flow_ctrl.sv
// Directed self-checking bench for fsm_flow_ctrl (NUM_FIFOS=10, LVL_W=3).
// Expected active_cycles depends on whether FSM_FLOW_STATS_EN is defined.
module tb_fsm_flow_ctrl;

    localparam int NF = 10;
    localparam int LW = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             init;
    logic [LW-1:0]    umbral_alto;
    logic [LW-1:0]    umbral_bajo;
    logic [NF-1:0]    fifo_empty;
    logic [NF*LW-1:0] fifo_level;
    logic [2:0]       state;
    logic             idle;
    logic             cfg_error;
    logic [LW-1:0]    interno_alto;
    logic [LW-1:0]    interno_bajo;
    logic [NF-1:0]    pause;
    logic [15:0]      active_cycles;

    int tests_run = 0;
    int tests_failed = 0;

`ifdef FSM_FLOW_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    fsm_flow_ctrl #(.NUM_FIFOS(NF), .LVL_W(LW)) dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .umbral_alto   (umbral_alto),
        .umbral_bajo   (umbral_bajo),
        .fifo_empty    (fifo_empty),
        .fifo_level    (fifo_level),
        .state         (state),
        .idle          (idle),
        .cfg_error     (cfg_error),
        .interno_alto  (interno_alto),
        .interno_bajo  (interno_bajo),
        .pause         (pause),
        .active_cycles (active_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
        $display("[TB] %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic set_level(input int idx, input logic [LW-1:0] v);
        fifo_level[idx*LW +: LW] = v;
    endtask

    logic [LW-1:0] ramp_lvl [14] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                                     3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    logic          ramp_exp [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                                     1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        reset = 1'b0; init = 1'b0;
        umbral_alto = 3'd6; umbral_bajo = 3'd2;
        fifo_empty = '1; fifo_level = '0;

        // 1: reset, then RESET -> INIT -> IDLE
        tick(); tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_pause", 32'(pause), 32'd0);
        check("rst_alto", 32'(interno_alto), 32'd0);
        check("rst_cfg_err", 32'(cfg_error), 32'd0);
        check("rst_idle", 32'(idle), 32'd0);
        reset = 1'b1;
        tick();
        check("init_state", 32'(state), 32'd1);
        tick();
        check("idle_state", 32'(state), 32'd2);
        check("idle_flag", 32'(idle), 32'd1);
        check("lat_alto", 32'(interno_alto), 32'd6);
        check("lat_bajo", 32'(interno_bajo), 32'd2);
        check("idle_pause", 32'(pause), 32'd0);

        // 2: IDLE <-> ACTIVE
        fifo_empty[3] = 1'b0;
        #1;
        check("idle_comb_drop", 32'(idle), 32'd0);
        tick();
        check("to_active", 32'(state), 32'd3);
        check("active_idle", 32'(idle), 32'd0);
        fifo_empty = '1;
        tick();
        check("back_idle", 32'(state), 32'd2);
        check("back_idle_flag", 32'(idle), 32'd1);

        // 3: hysteresis on FIFO 5
        fifo_empty[3] = 1'b0;
        tick();
        check("ramp_active", 32'(state), 32'd3);
        for (int i = 0; i < 14; i++) begin
            set_level(5, ramp_lvl[i]);
            tick();
            check($sformatf("ramp_pause_lvl%0d_step%0d", ramp_lvl[i], i),
                  32'(pause), ramp_exp[i] ? 32'h20 : 32'h0);
        end

        // 4: invalid config -> ERROR, valid config -> IDLE
        set_level(5, 3'd7);
        tick();
        check("pre_init_pause", 32'(pause), 32'h20);
        init = 1'b1; umbral_alto = 3'd2; umbral_bajo = 3'd2;
        tick();
        check("reinit_state", 32'(state), 32'd1);
        check("reinit_pause", 32'(pause), 32'd0);
        init = 1'b0; fifo_empty = '1;
        tick();
        check("err_state", 32'(state), 32'd4);
        check("err_cfg", 32'(cfg_error), 32'd1);
        check("err_alto", 32'(interno_alto), 32'd2);
        check("err_pause", 32'(pause), 32'd0);
        check("err_idle", 32'(idle), 32'd0);
        tick();
        check("err_stays", 32'(state), 32'd4);
        init = 1'b1; umbral_alto = 3'd5; umbral_bajo = 3'd1;
        tick();
        check("err_reinit", 32'(state), 32'd1);
        init = 1'b0;
        tick();
        check("ok_state", 32'(state), 32'd2);
        check("ok_cfg", 32'(cfg_error), 32'd0);
        check("ok_alto", 32'(interno_alto), 32'd5);
        check("ok_bajo", 32'(interno_bajo), 32'd1);

        // 5: reset mid-operation with pause asserted
        fifo_level = '0;
        fifo_empty[0] = 1'b0; set_level(0, 3'd6);
        tick();
        check("p0_active", 32'(state), 32'd3);
        tick();
        check("p0_pause", 32'(pause), 32'h1);
        reset = 1'b0;
        tick();
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_pause", 32'(pause), 32'd0);
        check("midrst_alto", 32'(interno_alto), 32'd0);
        check("midrst_bajo", 32'(interno_bajo), 32'd0);
        check("midrst_cfg", 32'(cfg_error), 32'd0);
        check("midrst_idle", 32'(idle), 32'd0);
        check("midrst_cnt", 32'(active_cycles), 32'd0);

        // 6: ACTIVE cycle counter
        reset = 1'b1; umbral_alto = 3'd6; umbral_bajo = 3'd2;
        fifo_level = '0; fifo_empty = '1;
        tick(); tick();
        check("cnt_idle", 32'(state), 32'd2);
        fifo_empty[2] = 1'b0;
        tick();
        check("cnt_active", 32'(state), 32'd3);
        check("cnt_start", 32'(active_cycles), 32'd0);
        for (int i = 0; i < 20; i++) tick();
        check("cnt_20", 32'(active_cycles), STATS ? 32'd20 : 32'd0);
        init = 1'b1;
        tick();
        check("cnt_clear_state", 32'(state), 32'd1);
        check("cnt_clear", 32'(active_cycles), 32'd0);
        init = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
